// File: rtl/run_detect_pkg.sv
// Shared types for the run-length detector: FSM state encoding and the run-count width helper.
package run_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_e;

  // Bits needed to hold a run count of 0..run_len inclusive.
  function automatic int cw_of(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_detect_sat_cnt.sv
// Generic saturating up-counter with synchronous clear (clear beats increment).
module run_detect_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_detect_moore.sv
// Moore detector flagging RUN_LEN consecutive sampled bits equal to MATCH_VAL.
// Define RUN_DETECT_CNT_EN to add the saturating hit counter (det_clr / det_cnt ports).
module run_detect_moore
  import run_detect_pkg::*;
#(
  parameter int   RUN_LEN   = 4,
  parameter logic MATCH_VAL = 1'b1,
  parameter bit   OVERLAP   = 1'b1,
  parameter int   CNT_W     = 8,
  localparam int  CW        = cw_of(RUN_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          inp,
  output logic          outp,
  output logic [CW-1:0] run_len_o
`ifdef RUN_DETECT_CNT_EN
  ,
  input  logic             det_clr,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  if (RUN_LEN < 2) begin : g_bad_run_len
    $error("run_detect_moore: RUN_LEN must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("run_detect_moore: CNT_W must be at least 1");
  end

  localparam logic [CW-1:0] K_ONE = CW'(1);
  localparam logic [CW-1:0] K_MAX = CW'(RUN_LEN);

  state_e        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic          outp_q, outp_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (en) begin
      if (inp != MATCH_VAL) begin
        state_d = ST_IDLE;
        k_d     = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_d = ST_RUN;
            k_d     = K_ONE;
          end
          ST_RUN: begin
            k_d = k_q + K_ONE;
            if (k_d == K_MAX) state_d = ST_HIT;
          end
          ST_HIT: begin
            // Overlap keeps re-firing on each extra match; otherwise the run restarts at 1.
            if (OVERLAP != 1'b0) begin
              state_d = ST_HIT;
              k_d     = K_MAX;
            end else begin
              state_d = ST_RUN;
              k_d     = K_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            k_d     = '0;
          end
        endcase
      end
    end
    outp_d = (state_d == ST_HIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      outp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      outp_q  <= outp_d;
    end
  end

  assign outp      = outp_q;
  assign run_len_o = k_q;

`ifdef RUN_DETECT_CNT_EN
  logic hit_evt;
  assign hit_evt = en && (state_d == ST_HIT);

  run_detect_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_det_cnt (
    .clk(clk),
    .rst(rst),
    .clr(det_clr),
    .inc(hit_evt),
    .cnt(det_cnt)
  );
`endif

endmodule

// File: tb/tb_run_detect_moore.sv
// Directed scoreboard bench for run_detect_moore: three parameterisations share clock and reset.
`timescale 1ns/1ps
module tb_run_detect_moore;

  typedef struct {
    string      tag;
    int         inst;
    logic       o;
    logic [2:0] k;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_v  [3];
  logic       inp_v [3];
  logic       o_v   [3];
  logic [2:0] k_v   [3];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef RUN_DETECT_CNT_EN
  logic       det_clr0 = 1'b0;
  logic [1:0] det_cnt0;
  logic [7:0] det_cnt1, det_cnt2;
`endif

  always #5 clk = ~clk;

  // inst 0: overlap, match 1, 2-bit hit counter
  run_detect_moore #(.RUN_LEN(4), .MATCH_VAL(1'b1), .OVERLAP(1'b1), .CNT_W(2)) u_ov (
    .clk(clk), .rst(rst), .en(en_v[0]), .inp(inp_v[0]), .outp(o_v[0]), .run_len_o(k_v[0])
`ifdef RUN_DETECT_CNT_EN
    , .det_clr(det_clr0), .det_cnt(det_cnt0)
`endif
  );

  // inst 1: restart after hit
  run_detect_moore #(.RUN_LEN(4), .MATCH_VAL(1'b1), .OVERLAP(1'b0)) u_no (
    .clk(clk), .rst(rst), .en(en_v[1]), .inp(inp_v[1]), .outp(o_v[1]), .run_len_o(k_v[1])
`ifdef RUN_DETECT_CNT_EN
    , .det_clr(1'b0), .det_cnt(det_cnt1)
`endif
  );

  // inst 2: runs of zeros
  run_detect_moore #(.RUN_LEN(4), .MATCH_VAL(1'b0), .OVERLAP(1'b1)) u_m0 (
    .clk(clk), .rst(rst), .en(en_v[2]), .inp(inp_v[2]), .outp(o_v[2]), .run_len_o(k_v[2])
`ifdef RUN_DETECT_CNT_EN
    , .det_clr(1'b0), .det_cnt(det_cnt2)
`endif
  );

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    n_tests++;
    assert (o_v[e.inst] === e.o) else begin
      n_fail++;
      $error("FAIL %s outp: observed %b required %b", e.tag, o_v[e.inst], e.o);
    end
    n_tests++;
    assert (k_v[e.inst] === e.k) else begin
      n_fail++;
      $error("FAIL %s run_len_o: observed %0d required %0d", e.tag, k_v[e.inst], e.k);
    end
  endtask

  // Drive one sample into instance inst (others hold), then check after the edge.
  task automatic step(input int inst, input logic e, input logic i,
                      input logic eo, input int ek, input string tag);
    for (int n = 0; n < 3; n++) begin
      en_v[n]  = 1'b0;
      inp_v[n] = 1'b0;
    end
    en_v[inst]  = e;
    inp_v[inst] = i;
    sb.push_back('{tag, inst, eo, 3'(ek)});
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic expect_now(input int inst, input logic eo, input int ek, input string tag);
    sb.push_back('{tag, inst, eo, 3'(ek)});
    check_front();
  endtask

`ifdef RUN_DETECT_CNT_EN
  task automatic chk_cnt(input int exp, input string tag);
    n_tests++;
    assert (det_cnt0 === 2'(exp)) else begin
      n_fail++;
      $error("FAIL %s det_cnt: observed %0d required %0d", tag, det_cnt0, exp);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 3; n++) begin
      en_v[n]  = 1'b0;
      inp_v[n] = 1'b0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) expect_now(n, 1'b0, 0, "reset");
`ifdef RUN_DETECT_CNT_EN
    chk_cnt(0, "reset_cnt");
`endif
    rst = 1'b1;

    // T1: overlap, 1,1,1,1,1,0
    step(0, 1, 1, 0, 1, "t1_b1");
    step(0, 1, 1, 0, 2, "t1_b2");
    step(0, 1, 1, 0, 3, "t1_b3");
    step(0, 1, 1, 1, 4, "t1_b4");
    step(0, 1, 1, 1, 4, "t1_b5");
    step(0, 1, 0, 0, 0, "t1_b6");

    // T2: no overlap, eight 1s then a 0
    step(1, 1, 1, 0, 1, "t2_b1");
    step(1, 1, 1, 0, 2, "t2_b2");
    step(1, 1, 1, 0, 3, "t2_b3");
    step(1, 1, 1, 1, 4, "t2_b4");
    step(1, 1, 1, 0, 1, "t2_b5");
    step(1, 1, 1, 0, 2, "t2_b6");
    step(1, 1, 1, 0, 3, "t2_b7");
    step(1, 1, 1, 1, 4, "t2_b8");
    step(1, 1, 0, 0, 0, "t2_b9");

    // T3: enable gap holds the run; en=0 also holds a HIT
    step(0, 1, 1, 0, 1, "t3_b1");
    step(0, 1, 1, 0, 2, "t3_b2");
    step(0, 0, 0, 0, 2, "t3_gap1");
    step(0, 0, 0, 0, 2, "t3_gap2");
    step(0, 0, 0, 0, 2, "t3_gap3");
    step(0, 1, 1, 0, 3, "t3_b3");
    step(0, 1, 1, 1, 4, "t3_b4");
    step(0, 0, 0, 1, 4, "t3_hold_hit");
    step(0, 1, 0, 0, 0, "t3_break");

    // T4: async reset mid-run, then a full fresh run is required
    step(0, 1, 1, 0, 1, "t4_b1");
    step(0, 1, 1, 0, 2, "t4_b2");
    step(0, 1, 1, 0, 3, "t4_b3");
    rst = 1'b0;
    #2;
    expect_now(0, 1'b0, 0, "t4_async");
    step(0, 1, 1, 0, 0, "t4_held");
    rst = 1'b1;
    step(0, 1, 1, 0, 1, "t4_r1");
    step(0, 1, 1, 0, 2, "t4_r2");
    step(0, 1, 1, 0, 3, "t4_r3");
    step(0, 1, 1, 1, 4, "t4_r4");
    step(0, 1, 0, 0, 0, "t4_break");

    // T5: MATCH_VAL=0, 0,0,1,0,0,0,0 then 1
    step(2, 1, 0, 0, 1, "t5_b1");
    step(2, 1, 0, 0, 2, "t5_b2");
    step(2, 1, 1, 0, 0, "t5_b3");
    step(2, 1, 0, 0, 1, "t5_b4");
    step(2, 1, 0, 0, 2, "t5_b5");
    step(2, 1, 0, 0, 3, "t5_b6");
    step(2, 1, 0, 1, 4, "t5_b7");
    step(2, 1, 1, 0, 0, "t5_b8");

`ifdef RUN_DETECT_CNT_EN
    // T6: hit counter (CNT_W=2 on inst 0)
    det_clr0 = 1'b1;
    step(0, 0, 0, 0, 0, "t6_clr");
    det_clr0 = 1'b0;
    chk_cnt(0, "t6_cleared");
    step(0, 1, 1, 0, 1, "t6_a1");
    step(0, 1, 1, 0, 2, "t6_a2");
    step(0, 1, 1, 0, 3, "t6_a3");
    step(0, 1, 1, 1, 4, "t6_a4");
    step(0, 1, 1, 1, 4, "t6_a5");
    step(0, 1, 0, 0, 0, "t6_a6");
    chk_cnt(2, "t6_t1_hits");
    det_clr0 = 1'b1;
    step(0, 0, 0, 0, 0, "t6_clr2");
    det_clr0 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      step(0, 1, 1, (n >= 4) ? 1'b1 : 1'b0, (n >= 4) ? 4 : n, "t6_sat");
    end
    chk_cnt(3, "t6_saturate");
    det_clr0 = 1'b1;
    step(0, 1, 1, 1, 4, "t6_clr_hit");
    det_clr0 = 1'b0;
    chk_cnt(0, "t6_clr_wins");
    step(0, 1, 1, 1, 4, "t6_after");
    chk_cnt(1, "t6_recount");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
